// File: rtl/branch_unit.sv
// Branch unit: status register, program counter and a three-state branch
// sequencer (IDLE -> EVAL -> UPDATE). The branch is accepted at edge T.
// Its condition and target are resolved at T+1. The pc, taken and br_done
// change at T+2.
// Optional feature: define BRANCH_LINK_EN to make condition 111 an
// always-taken branch-and-link that writes the link register. Without the
// macro, 111 is reserved (never taken) and lr is tied to zero.

module branch_unit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_s,
  input  logic [2:0] status_in,
  input  logic       pc_inc,
  input  logic       br_valid,
  input  logic [2:0] br_cond,
  input  logic [7:0] br_offset,
  output logic       br_ready,
  output logic       br_done,
  output logic       taken,
  output logic [8:0] pc,
  output logic [8:0] lr,
  output logic [2:0] status
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_NE     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_LE     = 3'b100;
  localparam logic [2:0] COND_LINK   = 3'b111;

  state_t     state;
  state_t     next_state;

  logic [2:0] cond_q;
  logic [7:0] offset_q;
  logic       take_q;
  logic [8:0] target_q;

  logic       accept;
  logic       cond_met;
  logic [8:0] pc_plus1;
  logic [8:0] branch_target;

  logic       flag_n;
  logic       flag_v;
  logic       flag_z;

  assign flag_n = status[2];
  assign flag_v = status[1];
  assign flag_z = status[0];

  assign pc_plus1      = pc + 9'd1;
  assign branch_target = pc_plus1 + {offset_q[7], offset_q};

  // Next state, ready flag and acceptance strobe
  always_comb begin
    next_state = state;
    br_ready   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        br_ready = 1'b1;
        if (br_valid) begin
          accept     = 1'b1;
          next_state = EVAL;
        end
      end
      EVAL:    next_state = UPDATE;
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Condition decode against the status register
  always_comb begin
    cond_met = 1'b0;
    case (cond_q)
      COND_ALWAYS: cond_met = 1'b1;
      COND_EQ:     cond_met = flag_z;
      COND_NE:     cond_met = ~flag_z;
      COND_LT:     cond_met = flag_n ^ flag_v;
      COND_LE:     cond_met = (flag_n ^ flag_v) | flag_z;
`ifdef BRANCH_LINK_EN
      COND_LINK:   cond_met = 1'b1;
`else
      COND_LINK:   cond_met = 1'b0;
`endif
      default:     cond_met = 1'b0;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Status flags load on any edge with load_s, regardless of sequencer state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status <= 3'b000;
    end else if (load_s) begin
      status <= status_in;
    end
  end

  // Capture the accepted request, then latch the resolved decision in EVAL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cond_q   <= 3'b000;
      offset_q <= 8'h00;
      take_q   <= 1'b0;
      target_q <= 9'h000;
    end else begin
      if (accept) begin
        cond_q   <= br_cond;
        offset_q <= br_offset;
      end
      if (state == EVAL) begin
        take_q   <= cond_met;
        target_q <= branch_target;
      end
    end
  end

  // Program counter, taken flag and completion pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc      <= 9'h000;
      taken   <= 1'b0;
      br_done <= 1'b0;
    end else begin
      br_done <= 1'b0;
      if (state == UPDATE) begin
        pc      <= take_q ? target_q : pc_plus1;
        taken   <= take_q;
        br_done <= 1'b1;
      end else if (state == IDLE && !br_valid && pc_inc) begin
        pc <= pc_plus1;
      end
    end
  end

`ifdef BRANCH_LINK_EN
  // Link register saves the return address on a branch-and-link
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lr <= 9'h000;
    end else if (state == UPDATE && cond_q == COND_LINK) begin
      lr <= pc_plus1;
    end
  end
`else
  assign lr = 9'h000;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed vectors, a transaction-level
// reference model, a per-cycle compare process and hand-computed literals.
// Honours BRANCH_LINK_EN to pick the expected behaviour of condition 111.

module tb_branch_unit;

`ifdef BRANCH_LINK_EN
  localparam bit LINK = 1'b1;
`else
  localparam bit LINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_s = 1'b0;
  logic [2:0] status_in = 3'b000;
  logic       pc_inc = 1'b0;
  logic       br_valid = 1'b0;
  logic [2:0] br_cond = 3'b000;
  logic [7:0] br_offset = 8'h00;
  logic       br_ready;
  logic       br_done;
  logic       taken;
  logic [8:0] pc;
  logic [8:0] lr;
  logic [2:0] status;

  int compared = 0;
  int mismatched = 0;

  branch_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_s    (load_s),
    .status_in (status_in),
    .pc_inc    (pc_inc),
    .br_valid  (br_valid),
    .br_cond   (br_cond),
    .br_offset (br_offset),
    .br_ready  (br_ready),
    .br_done   (br_done),
    .taken     (taken),
    .pc        (pc),
    .lr        (lr),
    .status    (status)
  );

  always #5 clk = ~clk;

  // Reference model state: architectural registers plus one pending branch
  logic [8:0] m_pc = 9'h000;
  logic [8:0] m_lr = 9'h000;
  logic [2:0] m_status = 3'b000;
  logic       m_taken = 1'b0;
  logic       m_done = 1'b0;
  logic       m_pend = 1'b0;
  int         m_age = 0;
  logic [2:0] m_cond = 3'b000;
  logic [7:0] m_off = 8'h00;
  logic [2:0] m_snap = 3'b000;

  function automatic bit condTaken(input logic [2:0] c, input logic [2:0] s);
    bit n;
    bit v;
    bit z;
    n = s[2];
    v = s[1];
    z = s[0];
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return n != v;
      3'd4:    return (n != v) || z;
      3'd7:    return LINK;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [2:0] st, input logic inc,
                               input logic vld, input logic [2:0] cnd, input logic [7:0] off);
    @(negedge clk);
    load_s    = ld;
    status_in = st;
    pc_inc    = inc;
    br_valid  = vld;
    br_cond   = cnd;
    br_offset = off;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 8'h00);
  endtask

  task automatic incPc(input int n);
    repeat (n) applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 8'h00);
    idle();
  endtask

  task automatic loadStatus(input logic [2:0] s);
    applyStimulus(1'b1, s, 1'b0, 1'b0, 3'b000, 8'h00);
    idle();
  endtask

  // Returns on the negedge just after the completion edge (br_done high)
  task automatic doBranch(input logic [2:0] c, input logic [7:0] off);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, c, off);
    idle();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Model: a branch resolves two edges after acceptance using status seen after the accept edge
  always @(posedge clk or negedge reset_n) begin : model
    logic [8:0] n_pc;
    logic [8:0] n_lr;
    logic [2:0] n_status;
    logic       n_taken;
    logic       n_done;
    logic       n_pend;
    int         n_age;
    logic [2:0] n_snap;
    bit         t;
    if (!reset_n) begin
      m_pc     <= 9'h000;
      m_lr     <= 9'h000;
      m_status <= 3'b000;
      m_taken  <= 1'b0;
      m_done   <= 1'b0;
      m_pend   <= 1'b0;
      m_age    <= 0;
    end else begin
      n_pc     = m_pc;
      n_lr     = m_lr;
      n_status = m_status;
      n_taken  = m_taken;
      n_done   = 1'b0;
      n_pend   = m_pend;
      n_age    = m_age;
      n_snap   = m_snap;
      if (m_pend) begin
        n_age = m_age + 1;
        if (n_age == 1) begin
          n_snap = m_status;
        end else begin
          t = condTaken(m_cond, m_snap);
          if (LINK && m_cond == 3'd7) n_lr = 9'(int'(m_pc) + 1);
          if (t) n_pc = 9'(int'(m_pc) + 1 + int'($signed(m_off)));
          else   n_pc = 9'(int'(m_pc) + 1);
          n_taken = t;
          n_done  = 1'b1;
          n_pend  = 1'b0;
        end
      end else if (br_valid) begin
        n_pend = 1'b1;
        n_age  = 0;
        m_cond <= br_cond;
        m_off  <= br_offset;
      end else if (pc_inc) begin
        n_pc = 9'(int'(m_pc) + 1);
      end
      if (load_s) n_status = status_in;
      m_pc     <= n_pc;
      m_lr     <= n_lr;
      m_status <= n_status;
      m_taken  <= n_taken;
      m_done   <= n_done;
      m_pend   <= n_pend;
      m_age    <= n_age;
      m_snap   <= n_snap;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    checkOutput("cyc_pc", pc, m_pc);
    checkOutput("cyc_lr", lr, m_lr);
    checkOutput("cyc_status", status, m_status);
    checkOutput("cyc_taken", taken, m_taken);
    checkOutput("cyc_done", br_done, m_done);
    checkOutput("cyc_ready", br_ready, !m_pend);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    checkOutput("reset_pc", pc, 9'h000);
    checkOutput("reset_ready", br_ready, 1'b1);

    incPc(3);
    checkOutput("inc3_pc", pc, 9'h003);
    loadStatus(3'b101);
    checkOutput("load_status", status, 3'b101);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_pc", pc, 9'h000);
    checkOutput("async_status", status, 3'b000);
    checkOutput("async_ready", br_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    incPc(16);
    loadStatus(3'b001);
    doBranch(3'b001, 8'h05);
    checkOutput("beq_t_pc", pc, 9'h016);
    checkOutput("beq_t_taken", taken, 1'b1);
    checkOutput("beq_t_done", br_done, 1'b1);
    @(negedge clk);
    checkOutput("beq_t_done_clr", br_done, 1'b0);

    doReset();
    incPc(16);
    doBranch(3'b001, 8'h05);
    checkOutput("beq_nt_pc", pc, 9'h011);
    checkOutput("beq_nt_taken", taken, 1'b0);
    doBranch(3'b010, 8'hFE);
    checkOutput("bne_pc", pc, 9'h010);
    checkOutput("bne_taken", taken, 1'b1);

    incPc(9'h1EF);
    checkOutput("pc_1ff", pc, 9'h1FF);
    loadStatus(3'b100);
    doBranch(3'b011, 8'h00);
    checkOutput("blt_wrap_pc", pc, 9'h000);
    checkOutput("blt_taken", taken, 1'b1);
    loadStatus(3'b001);
    doBranch(3'b100, 8'h03);
    checkOutput("ble_pc", pc, 9'h004);
    checkOutput("ble_taken", taken, 1'b1);
    doBranch(3'b101, 8'h10);
    checkOutput("rsvd_pc", pc, 9'h005);
    checkOutput("rsvd_taken", taken, 1'b0);
    doBranch(3'b000, 8'h80);
    checkOutput("bal_neg_pc", pc, 9'h186);

    applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 3'b000, 8'h02);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 3'b000, 8'h02);
    checkOutput("hold_ready_eval", br_ready, 1'b0);
    checkOutput("hold_no_inc", pc, 9'h186);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 3'b000, 8'h02);
    idle();
    checkOutput("hold_pc", pc, 9'h189);
    checkOutput("hold_done", br_done, 1'b1);
    @(negedge clk);
    checkOutput("hold_single_pc", pc, 9'h189);
    checkOutput("hold_single_ready", br_ready, 1'b1);

    applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 8'h05);
    idle();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_pc", pc, 9'h000);
    checkOutput("midrst_done", br_done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_pc_after", pc, 9'h000);
    checkOutput("midrst_taken", taken, 1'b0);

    incPc(32);
    doBranch(3'b111, 8'h10);
    checkOutput("link_pc", pc, LINK ? 9'h031 : 9'h021);
    checkOutput("link_lr", lr, LINK ? 9'h021 : 9'h000);
    checkOutput("link_taken", taken, LINK);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
